// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared types for the parcel-based instruction fetch unit:
//                fetch FSM state encoding and the prefetch FIFO entry.
//  Revision    : 1.0  initial release
// ============================================================================
package ifetch_pkg;

    localparam int PARCEL_W = 16;

    // FIFO entries carry a PC field wide enough for any supported RV (<= 64);
    // the unused upper bits are tied to zero and trimmed by synthesis.
    localparam int PC_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_MAX_W-1:1] pc;
        logic [PARCEL_W-1:0] ins;
    } parcel_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_parcel_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_parcel_if
//  Description : Bundle of the fetch unit's control, instruction-memory and
//                decoder-side signals. master = fetch unit, slave = its
//                environment (execute stage, memory, decoder).
//  Revision    : 1.0  initial release
// ============================================================================
interface ifetch_parcel_if #(
    parameter int RV = 32
);
    logic          stall;
    logic          redirect;
    logic [RV-1:0] redirect_pc;
    logic          imem_req;
    logic [RV-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [15:0]   ins;
    logic          idone;
    logic [RV-1:0] ipc;

    modport master (
        input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, ins, idone, ipc
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, ins, idone, ipc
    );
endinterface
`default_nettype wire

// File: rtl/parcel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : parcel_fifo
//  Description : Prefetch FIFO of 16-bit parcels. Up to two pushes (push1
//                only together with push0) and one pop per cycle, with a
//                synchronous clear that overrides everything else.
//  Revision    : 1.0  initial release
// ============================================================================
module parcel_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 clear_i,
    input  wire logic                 push0_i,
    input  wire logic                 push1_i,
    input  wire parcel_t              push0_data_i,
    input  wire parcel_t              push1_data_i,
    input  wire logic                 pop_i,
    output parcel_t                   head_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [$clog2(DEPTH):0]    free_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    parcel_t        mem_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [CW-1:0]  count_q;
    logic [AW-1:0]  w_wr_ptr1;
    logic [1:0]     w_push_n;

    assign w_wr_ptr1 = wr_ptr_q + 1'b1;
    assign w_push_n  = {1'b0, push0_i} + {1'b0, push1_i};

    // Storage: the second pushed parcel lands in the slot after the first.
    always_ff @(posedge clk) begin
        if (!clear_i) begin
            if (push0_i) mem_q[wr_ptr_q]  <= push0_data_i;
            if (push1_i) mem_q[w_wr_ptr1] <= push1_data_i;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(w_push_n);
            rd_ptr_q <= rd_ptr_q + AW'(pop_i);
            count_q  <= count_q + CW'(w_push_n) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign free_o  = CW'(DEPTH) - count_q;

endmodule
`default_nettype wire

// File: rtl/ifetch_parcel.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_parcel
//  Description : Instruction fetch front end. Fetches 32-bit words, splits
//                them into 16-bit parcels, buffers them in a prefetch FIFO
//                and hands one parcel per cycle (with its PC) to the decoder.
//                Redirects flush the FIFO and discard in-flight fetches.
//  Revision    : 1.0  initial release
// ============================================================================
module ifetch_parcel
    import ifetch_pkg::*;
#(
    parameter int            RV       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [RV-1:0] RESET_PC = '0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    ifetch_parcel_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e        state_q, state_d;
    logic [RV-1:0]       fetch_pc_q, fetch_pc_d;
    logic [RV-1:0]       addr_q, addr_d;
    logic [RV-1:0]       ipc_q;
    logic [PARCEL_W-1:0] ins_q;
    logic                idone_q;

    logic [RV-1:0]       w_pc_word;
    logic [RV-1:0]       w_redir_pc;
    logic                w_slots_ok;
    logic                w_accept;
    logic                w_push0;
    logic                w_push1;
    logic                w_pop;
    parcel_t             w_push0_data;
    parcel_t             w_push1_data;
    parcel_t             w_head;
    logic [CW-1:0]       w_count;
    logic [CW-1:0]       w_free;

    assign w_pc_word  = fetch_pc_q & ~RV'(3);
    assign w_redir_pc = bus.redirect_pc & ~RV'(1);

    // An upper-half start needs one slot, a word-aligned start needs two.
    assign w_slots_ok = (w_free >= CW'(2)) || (fetch_pc_q[1] && (w_free != '0));

    // Only data from a live (non-discarded, non-redirected) request is kept.
    assign w_accept = (state_q == ST_REQ) && bus.imem_ack && !bus.redirect;
    assign w_push0  = w_accept;
    assign w_push1  = w_accept && !fetch_pc_q[1];
    assign w_pop    = (w_count != '0) && !bus.stall && !bus.redirect;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; an accepted ack always returns to IDLE so that
    // back-to-back requests are separated by one idle cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A redirect clears the FIFO, so a request can always start.
                if (bus.redirect || w_slots_ok) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.imem_ack)     state_d = ST_IDLE;
                else if (bus.redirect) state_d = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (bus.imem_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: the request is outstanding in every non-idle state.
    always_comb begin
        bus.imem_req  = (state_q != ST_IDLE);
        bus.imem_addr = addr_q;
        bus.ins       = ins_q;
        bus.idone     = idone_q;
        bus.ipc       = ipc_q;
    end

    // Fetch PC and request address next values; the address is captured
    // only when a request is launched and held until its ack.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect)  fetch_pc_d = w_redir_pc;
        else if (w_accept) fetch_pc_d = w_pc_word + RV'(4);

        addr_d = addr_q;
        if (state_q == ST_IDLE && state_d == ST_REQ) begin
            addr_d = bus.redirect ? (w_redir_pc & ~RV'(3)) : w_pc_word;
        end
    end

    // Parcel entries built from the returned word.
    always_comb begin
        w_push0_data = '0;
        w_push1_data = '0;
        w_push0_data.pc[RV-1:1] = fetch_pc_q[RV-1:1];
        w_push0_data.ins        = fetch_pc_q[1] ? bus.imem_rdata[31:16]
                                                : bus.imem_rdata[15:0];
        w_push1_data.pc[RV-1:1] = {fetch_pc_q[RV-1:2], 1'b1};
        w_push1_data.ins        = bus.imem_rdata[31:16];
    end

    // Fetch PC and held request address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC & ~RV'(1);
            addr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    // Decoder-side output register: ins/ipc hold while idone is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idone_q <= 1'b0;
            ins_q   <= '0;
            ipc_q   <= '0;
        end else begin
            idone_q <= w_pop;
            if (w_pop) begin
                ins_q <= w_head.ins;
                ipc_q <= {w_head.pc[RV-1:1], 1'b0};
            end
        end
    end

    // PC bits above RV are always zero in FIFO entries.
    if (RV < PC_MAX_W) begin : g_pc_hi
        logic w_unused_pc_hi;
        assign w_unused_pc_hi = ^w_head.pc[PC_MAX_W-1:RV];
    end

    parcel_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (bus.redirect),
        .push0_i      (w_push0),
        .push1_i      (w_push1),
        .push0_data_i (w_push0_data),
        .push1_data_i (w_push1_data),
        .pop_i        (w_pop),
        .head_o       (w_head),
        .count_o      (w_count),
        .free_o       (w_free)
    );

endmodule
`default_nettype wire

// File: tb/tb_ifetch_parcel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_parcel
//  Description : Self-checking bench for ifetch_parcel. Acts as instruction
//                memory and execute stage; a parcel-stream reference model
//                predicts every idone, ins, ipc and request address.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifetch_parcel;
    localparam int          RV     = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h100;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ifetch_parcel_if #(.RV(RV)) bus();

    ifetch_parcel #(
        .RV       (RV),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] ovr [logic [31:0]];

    // Reference model: mf_pc = next parcel address to fetch, exp_pc = next
    // parcel address the decoder should see, occ = parcels buffered.
    logic [31:0] mf_pc, exp_pc, req_addr, last_ipc;
    logic [15:0] last_ins;
    int          occ, wait_n, lat_t, lat_cfg, acks_taken;
    bit          req_out, req_stale;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (ovr.exists(w)) return ovr[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [15:0] parcel(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word(pc);
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic bit ack_now();
        return req_out && (wait_n >= lat_t);
    endfunction

    task automatic model_reset();
        mf_pc     = RST_PC;
        exp_pc    = RST_PC;
        occ       = 0;
        req_out   = 1'b0;
        req_stale = 1'b0;
        wait_n    = 0;
        lat_t     = 0;
        last_ins  = '0;
        last_ipc  = '0;
    endtask

    // One clock: drive inputs, advance the model over the edge, then check.
    task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc);
        bit ack, exp_idone;
        int pushes, need;
        ack = ack_now();
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_ack    = ack;
        bus.imem_rdata  = ack ? mem_word(req_addr) : $urandom();

        exp_idone = (occ > 0) && !st && !rd;
        pushes = 0;
        if (ack) begin
            if (!req_stale && !rd) begin
                pushes = mf_pc[1] ? 1 : 2;
                mf_pc  = (mf_pc & ~32'h3) + 32'h4;
                acks_taken++;
            end
            req_out = 1'b0;
        end else if (req_out) begin
            wait_n++;
        end
        occ = occ + pushes - (exp_idone ? 1 : 0);
        if (rd) begin
            if (req_out) req_stale = 1'b1;
            occ    = 0;
            mf_pc  = rpc & ~32'h1;
            exp_pc = rpc & ~32'h1;
        end

        @(posedge clk);
        @(negedge clk);

        chk("idone", bus.idone, exp_idone);
        if (exp_idone) begin
            chk("ipc", bus.ipc, exp_pc);
            chk("ins", bus.ins, parcel(exp_pc));
            last_ins = parcel(exp_pc);
            last_ipc = exp_pc;
            exp_pc   = exp_pc + 32'h2;
        end else begin
            chk("ins_hold", bus.ins, last_ins);
            chk("ipc_hold", bus.ipc, last_ipc);
        end

        if (ack) begin
            chk("req_drop_after_ack", bus.imem_req, 1'b0);
        end else if (req_out) begin
            chk("req_hold", bus.imem_req, 1'b1);
            chk("addr_hold", bus.imem_addr, req_addr);
        end else if (bus.imem_req) begin
            req_out   = 1'b1;
            req_stale = 1'b0;
            wait_n    = 0;
            lat_t     = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
            req_addr  = bus.imem_addr;
            need      = mf_pc[1] ? 1 : 2;
            chk("req_addr", bus.imem_addr, mf_pc & ~32'h3);
            chk("req_slots", (rd || ((DEPTH - (occ + (exp_idone ? 1 : 0))) >= need)), 1'b1);
        end
    endtask

    initial begin
        bit found;
        int acks0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        ovr[32'h100] = 32'h2222_1111;
        ovr[32'h204] = 32'hBBBB_AAAA;
        acks_taken = 0;
        lat_cfg    = 1;
        model_reset();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_idone", bus.idone, 1'b0);
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_ins", bus.ins, 16'h0);
        chk("rst_ipc", bus.ipc, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        reset = 1'b1;

        // Fetch from RESET_PC, ack one cycle after the request
        repeat (10) cycle(1'b0, 1'b0, 32'h0);

        // Redirect to an upper-half parcel (bit 0 set, ignored)
        cycle(1'b0, 1'b1, 32'h207);
        repeat (10) cycle(1'b0, 1'b0, 32'h0);

        // Redirect while a slow request at 0x104 is outstanding
        lat_cfg = 3;
        cycle(1'b1, 1'b1, 32'h104);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (req_out && req_addr == 32'h104 && !ack_now()) found = 1'b1;
            else cycle(1'b1, 1'b0, 32'h0);
        end
        chk("t3_found", found, 1'b1);
        cycle(1'b0, 1'b1, 32'h400);
        repeat (14) cycle(1'b0, 1'b0, 32'h0);

        // Long stall: FIFO fills with exactly two words, then drains
        lat_cfg = 1;
        cycle(1'b1, 1'b1, 32'h300);
        acks0 = acks_taken;
        repeat (10) cycle(1'b1, 1'b0, 32'h0);
        chk("t4_words", acks_taken - acks0, 2);
        repeat (8) cycle(1'b0, 1'b0, 32'h0);

        // Address wrap at the top of the address space
        lat_cfg = 0;
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (10) cycle(1'b0, 1'b0, 32'h0);

        // Redirect coinciding with an ack while the FIFO holds parcels
        lat_cfg = 2;
        cycle(1'b1, 1'b1, 32'h500);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (occ > 0 && ack_now()) found = 1'b1;
            else cycle(1'b1, 1'b0, 32'h0);
        end
        chk("t6_found", found, 1'b1);
        cycle(1'b0, 1'b1, 32'h600);
        repeat (10) cycle(1'b0, 1'b0, 32'h0);

        // Asynchronous reset in the middle of a request
        lat_cfg = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (req_out && !ack_now()) found = 1'b1;
            else cycle(1'b0, 1'b0, 32'h0);
        end
        chk("rst_mid_found", found, 1'b1);
        bus.imem_ack = 1'b0;
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_req", bus.imem_req, 1'b0);
        chk("rst_mid_idone", bus.idone, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (10) cycle(1'b0, 1'b0, 32'h0);

        // Randomized traffic
        lat_cfg = -1;
        for (int i = 0; i < 3000; i++) begin
            bit          st, rd;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 4);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : 32'($urandom());
            cycle(st, rd, rpc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
